// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the register access arbiter.
// The optional lock feature is selected with the REG_ARB_LOCK_EN macro.
package reg_arb_pkg;

  localparam int unsigned REG_ARB_NUM_REQ = 4;
  localparam int unsigned REG_ARB_DATA_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StDone
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search begins one past the last owner and wraps.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx
);

  int unsigned      pos;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    pos        = 0;
    idx        = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      pos = (32'(last) + off) % NUM_REQ;
      idx = pos[IDX_W-1:0];
      if (!found && req[idx]) begin
        found          = 1'b1;
        winner_oh[idx] = 1'b1;
        winner_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one register between requesters over req/gnt/rsp.
// Defining REG_ARB_LOCK_EN adds req_lock for back-to-back transactions by one owner.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = REG_ARB_NUM_REQ,
  parameter int unsigned DATA_W  = REG_ARB_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      reg_read_enable,
  output logic                      reg_write_enable,
  output logic [DATA_W-1:0]         reg_write_data,
  input  logic [DATA_W-1:0]         reg_read_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] owner_oh;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last       (last_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx)
  );

  assign owner_oh  = NUM_REQ'(1) << owner_q;
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d = pick_idx;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
              we_d    = req_we[i];
              wdata_d = req_wdata[i*DATA_W +: DATA_W];
            end
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = we_q ? StDone : StCapture;
      end
      StCapture: begin
        rdata_d = reg_read_data;
        state_d = StDone;
      end
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
`ifdef REG_ARB_LOCK_EN
        // Locked owner keeps the grant; last only moves once ownership is released.
        if (req_lock[owner_q] && req[owner_q]) begin
          last_d  = last_q;
          we_d    = req_we[owner_q];
          wdata_d = req_wdata[32'(owner_q)*DATA_W +: DATA_W];
          state_d = StIssue;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  always_comb begin
    gnt              = '0;
    rsp_valid        = '0;
    reg_read_enable  = 1'b0;
    reg_write_enable = 1'b0;
    reg_write_data   = '0;
    unique case (state_q)
      StIdle: ;
      StIssue: begin
        gnt              = owner_oh;
        reg_write_enable = we_q;
        reg_read_enable  = ~we_q;
        reg_write_data   = wdata_q;
      end
      StCapture: gnt = owner_oh;
      StDone: begin
        gnt       = owner_oh;
        rsp_valid = owner_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Randomized bench for reg_access_arbiter against a transaction-timeline reference model.
module tb_reg_access_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   req_we;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_rdata;
  logic           reg_read_enable;
  logic           reg_write_enable;
  logic [W-1:0]   reg_write_data;
  logic [W-1:0]   reg_read_data = '0;
`ifdef REG_ARB_LOCK_EN
  logic [N-1:0]   req_lock = '0;
`endif

  reg_access_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_we           (req_we),
`ifdef REG_ARB_LOCK_EN
    .req_lock         (req_lock),
`endif
    .req_wdata        (req_wdata),
    .gnt              (gnt),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .reg_read_enable  (reg_read_enable),
    .reg_write_enable (reg_write_enable),
    .reg_write_data   (reg_write_data),
    .reg_read_data    (reg_read_data)
  );

  always #5 clk = ~clk;

  // Register datapath: write on the edge, read data valid the cycle after read_enable.
  logic [W-1:0] reg_store = '0;
  always @(posedge clk) begin
    if (reg_write_enable) reg_store <= reg_write_data;
    if (reg_read_enable) reg_read_data <= reg_store;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction occupies cycles 1..len after its IDLE cycle.
  int           m_owner;
  int           m_k;
  int           m_len;
  int           m_last;
  bit           m_we;
  logic [W-1:0] m_wd;
  logic [W-1:0] m_mem = '0;
  logic [W-1:0] m_hold;
  logic [N-1:0] e_gnt;
  logic [N-1:0] e_rsp;
  bit           pend [N];

  task automatic model_reset();
    m_owner = -1;
    m_k     = 0;
    m_len   = 0;
    m_last  = N - 1;
    m_hold  = '0;
  endtask

  task automatic compare_cycle();
    logic en_w, en_r;
    e_gnt = '0;
    e_rsp = '0;
    en_w  = 1'b0;
    en_r  = 1'b0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      if (m_k == 1) begin
        en_w = m_we;
        en_r = !m_we;
      end
      if (m_k == m_len) begin
        e_rsp[m_owner] = 1'b1;
        if (!m_we) m_hold = m_mem;
      end
    end
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    check("write_enable", 32'(reg_write_enable), 32'(en_w));
    check("read_enable", 32'(reg_read_enable), 32'(en_r));
    check("rsp_rdata", 32'(rsp_rdata), 32'(m_hold));
    if (en_w) check("write_data", 32'(reg_write_data), 32'(m_wd));
  endtask

  task automatic model_step();
    if (m_owner < 0) begin
      if (req != '0) begin
        for (int off = 1; off <= N; off++) begin
          int idx;
          idx = (m_last + off) % N;
          if (m_owner < 0 && req[idx]) m_owner = idx;
        end
        m_k   = 1;
        m_we  = req_we[m_owner];
        m_wd  = req_wdata[m_owner*W +: W];
        m_len = m_we ? 2 : 3;
      end
    end else begin
      if (m_k == 1 && m_we) m_mem = m_wd;
      if (m_k == m_len) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic start_req(input int i);
    pend[i]            = 1'b1;
    req[i]             = 1'b1;
    req_we[i]          = 1'($urandom_range(0, 1));
    req_wdata[i*W +: W] = W'($urandom);
  endtask

  task automatic drive_agents();
    for (int i = 0; i < N; i++) begin
      if (pend[i] && e_rsp[i]) begin
        pend[i] = 1'b0;
        if ($urandom_range(0, 3) == 0) start_req(i);
        else req[i] = 1'b0;
      end else if (!pend[i]) begin
        if ($urandom_range(0, 2) == 0) start_req(i);
      end else if (e_gnt[i]) begin
        // Owner may scramble its inputs or drop req once latched.
        if ($urandom_range(0, 2) == 0) begin
          req_we[i]           = 1'($urandom_range(0, 1));
          req_wdata[i*W +: W] = W'($urandom);
        end
        if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
      end
    end
  endtask

  task automatic clear_agents();
    req       = '0;
    req_we    = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  int n_resets = 0;

  initial begin
    reset = 1'b0;
    clear_agents();
    model_reset();
    e_gnt = '0;
    e_rsp = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("rst_write_enable", 32'(reg_write_enable), 32'h0);
    check("rst_read_enable", 32'(reg_read_enable), 32'h0);
    check("rst_write_data", 32'(reg_write_data), 32'h0);
    reset = 1'b1;

    // Directed opener: requester 1 writes AAAA, requester 2 reads it back.
    req[1] = 1'b1; req_we[1] = 1'b1; req_wdata[1*W +: W] = 16'hAAAA; pend[1] = 1'b1;
    model_step();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      compare_cycle();
      if (e_rsp[1]) begin req[1] = 1'b0; pend[1] = 1'b0; end
      model_step();
    end
    @(negedge clk);
    compare_cycle();
    req[2] = 1'b1; req_we[2] = 1'b0; pend[2] = 1'b1;
    model_step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compare_cycle();
      if (e_rsp[2]) begin
        check("read_back", 32'(rsp_rdata), 32'h0000AAAA);
        req[2] = 1'b0; pend[2] = 1'b0;
      end
      model_step();
    end

    // All requesters at once, then free-running random traffic.
    for (int i = 0; i < N; i++) start_req(i);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      compare_cycle();
      if (m_owner >= 0 && !m_we && m_k == 2 && n_resets < 4 && cyc > 200 * (n_resets + 1)) begin
        n_resets++;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_read_enable", 32'(reg_read_enable), 32'h0);
        check("mid_rst_write_enable", 32'(reg_write_enable), 32'h0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        clear_agents();
        model_reset();
        e_gnt = '0;
        e_rsp = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) start_req(i);
      end else begin
        drive_agents();
      end
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Round-robin arbiter that shares one 16-bit `Register` instance between several requesters. Each requester issues a single read or write through a req/gnt/rsp handshake. The arbiter sequences the register's `read_enable`/`write_enable` strobes, captures read data and returns it to the winning requester. It sits between the requester ports and the `Register` datapath, and is the only block that drives that register's control inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DATA_W`, 16: register data width
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester request; held high until the matching `rsp_valid`
- `req_we`  in  NUM_REQ  per-requester operation: 1 = write, 0 = read
- `req_wdata`  in  NUM_REQ*DATA_W  per-requester write data; requester i uses slice [i*DATA_W +: DATA_W]
- `gnt`  out  NUM_REQ  one-hot owner indication
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse to the owner
- `rsp_rdata`  out  DATA_W  read data; valid only while `rsp_valid` is high for a read
- `reg_read_enable`  out  1  to Register `read_enable`
- `reg_write_enable`  out  1  to Register `write_enable`
- `reg_write_data`  out  DATA_W  to Register `write_data`
- `reg_read_data`  in  DATA_W  from Register `read_data`; valid in the cycle after `reg_read_enable`

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- **IDLE**
  - If any `req` bit is high, pick a winner by round-robin. The search starts at `last+1` mod NUM_REQ.
  - On the edge, latch the owner index, its `req_we` bit and its `req_wdata` slice, then go to ISSUE.
  - If no `req` bit is high, stay in IDLE.
- **ISSUE** (1 cycle)
  - Drive `reg_write_enable` = latched we and `reg_read_enable` = not latched we.
  - Drive `reg_write_data` = latched wdata.
  - A write goes to DONE; a read goes to CAPTURE.
- **CAPTURE** (1 cycle, reads only)
  - Both enables are low.
  - Register `reg_read_data` into `rdata_q` at the end of the cycle, then go to DONE.
- **DONE** (1 cycle)
  - Assert `rsp_valid[owner]` and drive `rsp_rdata` = `rdata_q`.
  - Set `last` = owner, then go to IDLE.
- `gnt[owner]` is high from ISSUE through DONE inclusive. `gnt` is 0 in IDLE.
- Enables are 0 in every state except ISSUE. At most one of the two enables is high in any cycle.
- Dropping `req` after the grant does not abort the transaction; it completes normally. Changes to `req_we` or `req_wdata` after latching are ignored.
- A requester whose `req` stays high after DONE is treated as a new request in the next IDLE arbitration.
- `rsp_rdata` holds its last value outside DONE. It is unchanged by writes.

## Timing
- Reset values:
  - FSM = IDLE
  - `gnt` = 0, `rsp_valid` = 0, `rsp_rdata` = 0
  - both enables = 0, `reg_write_data` = 0
  - `last` = NUM_REQ-1, so requester 0 wins first
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous). The transaction is dropped with no `rsp_valid`. Register contents are not touched by the arbiter.
- Latency, with `req` first high in IDLE cycle 0:
  - write: ISSUE in cycle 1, DONE in cycle 2
  - read: ISSUE in cycle 1, CAPTURE in cycle 2, DONE in cycle 3
- Throughput without lock: one write per 3 cycles, one read per 4 cycles (the IDLE cycle is included).
- Simultaneous requests are served strictly in round-robin order. With all NUM_REQ requesting continuously, each requester waits at most NUM_REQ-1 transactions.
- Wrap-around: when `last` = NUM_REQ-1, the search starts at index 0.

## Configuration
- `REG_ARB_LOCK_EN` defined:
  - Adds input `req_lock` (NUM_REQ bits).
  - If `req_lock[owner]` and `req[owner]` are both high in DONE, the FSM goes directly to ISSUE. It re-latches that owner's `req_we` and `req_wdata`, and `gnt` stays high.
  - This gives back-to-back transactions: a write every 2 cycles, a read every 3.
  - `last` is updated only when ownership is released.
- `REG_ARB_LOCK_EN` not defined: the port is absent, every transaction returns through IDLE, and behaviour is pure round-robin.

## Structure
- Package `reg_arb_pkg`:
  - FSM state enum
  - default constants `REG_ARB_NUM_REQ`, `REG_ARB_DATA_W`
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and `last`; outputs are the one-hot winner and the winner index.

## Test plan
- Reset, then requester 1 writes 16'hAAAA: `gnt` = 4'b0010 in cycles 1–2, `reg_write_enable` high in cycle 1 only, `rsp_valid[1]` in cycle 2.
- After that write, requester 2 reads: `reg_read_enable` high in cycle 1, `rsp_valid[2]` in cycle 3 with `rsp_rdata` = 16'hAAAA.
- All four requesters request in the same cycle right after reset: grants occur in order 0, 1, 2, 3. A repeat request from 0 is served after 3.
- Requester 0 drops `req` during ISSUE: the transaction still reaches DONE with `rsp_valid[0]`, then the FSM returns to IDLE with no further grant.
- `reset` asserted during CAPTURE: `gnt`, enables and `rsp_valid` are 0 in the same cycle. After release, requester 0 is granted first.
- With `REG_ARB_LOCK_EN`, requester 3 holds lock for two writes, 16'h1234 then 16'h5678, while requester 0 is also requesting: the writes occur in consecutive 2-cycle slots, and requester 0 is granted only after lock is released.
